// File: rtl/lmac_reg_rd_arbiter.sv
// Round-robin arbiter/sequencer sharing the single LMAC register-read port among NUM_REQ requesters.
// Optional WAIT-state timeout is built when LMAC_REG_RD_TIMEOUT_EN is defined.
//
// state | meaning
// IDLE  | no transaction in flight; a winner is chosen when any req bit is set
// ARB   | owner granted, host_addr holds the owner's offset
// ISSUE | one-cycle reg_rd_start pulse to LMAC
// WAIT  | waiting for reg_rd_done_out (or the timeout limit)
// RESP  | one-cycle rsp_valid to the owner, ptr moves to the owner
module lmac_reg_rd_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                   i_reg_clk,
  input  logic                   i_reset,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [16*NUM_REQ-1:0]  i_req_addr,
  output logic [NUM_REQ-1:0]     o_gnt,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [31:0]            o_rsp_data,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic [15:0]            o_host_addr,
  output logic                   o_reg_rd_start,
  input  logic                   i_reg_rd_done_out,
  input  logic [31:0]            i_mac_regdout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("lmac_reg_rd_arbiter: NUM_REQ or TIMEOUT out of range");
  end

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ARB   = 5'b00010,
    S_ISSUE = 5'b00100,
    S_WAIT  = 5'b01000,
    S_RESP  = 5'b10000
  } state_t;

  state_t               r_state;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        r_owner;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_rsp_valid;
  logic [31:0]          r_rsp_data;
  logic                 r_busy;
  logic [15:0]          r_host_addr;
  logic                 r_reg_rd_start;

  logic [PW-1:0]        w_cand;
  logic [PW-1:0]        w_win_idx;
  logic [NUM_REQ-1:0]   w_win_oh;
  logic                 w_win_found;
  logic [15:0]          w_addr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign w_addr[g] = i_req_addr[16*g +: 16];
  end

  // Rotating priority: the first set req bit after ptr wins.
  always_comb begin
    w_cand      = '0;
    w_win_idx   = r_ptr;
    w_win_oh    = '0;
    w_win_found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = PW'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_win_found && i_req[w_cand]) begin
        w_win_found        = 1'b1;
        w_win_idx          = w_cand;
        w_win_oh           = '0;
        w_win_oh[w_cand]   = 1'b1;
      end
    end
  end

`ifdef LMAC_REG_RD_TIMEOUT_EN
  logic [15:0] r_wait_cnt;
  logic        r_rsp_err;
`endif

  // The winner is resolved from the req sampled in IDLE so that gnt and
  // host_addr are already registered while the FSM sits in ARB.
  always_ff @(posedge i_reg_clk) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_ptr          <= PW'(NUM_REQ - 1);
      r_owner        <= '0;
      r_gnt          <= '0;
      r_rsp_valid    <= '0;
      r_rsp_data     <= '0;
      r_busy         <= 1'b0;
      r_host_addr    <= '0;
      r_reg_rd_start <= 1'b0;
`ifdef LMAC_REG_RD_TIMEOUT_EN
      r_wait_cnt     <= '0;
      r_rsp_err      <= 1'b0;
`endif
    end else begin
      r_reg_rd_start <= 1'b0;
      r_rsp_valid    <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_state     <= S_ARB;
            r_owner     <= w_win_idx;
            r_gnt       <= w_win_oh;
            r_host_addr <= w_addr[w_win_idx];
            r_busy      <= 1'b1;
          end
        end
        S_ARB: begin
          r_state        <= S_ISSUE;
          r_reg_rd_start <= 1'b1;
        end
        S_ISSUE: begin
          r_state <= S_WAIT;
`ifdef LMAC_REG_RD_TIMEOUT_EN
          r_wait_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (i_reg_rd_done_out) begin
            r_state     <= S_RESP;
            r_rsp_data  <= i_mac_regdout;
            r_rsp_valid <= r_gnt;
`ifdef LMAC_REG_RD_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
          end else if (r_wait_cnt == 16'(TIMEOUT - 1)) begin
            r_state     <= S_RESP;
            r_rsp_data  <= 32'hDEAD_BEEF;
            r_rsp_valid <= r_gnt;
            r_rsp_err   <= 1'b1;
          end else begin
            r_wait_cnt  <= r_wait_cnt + 16'd1;
`endif
          end
        end
        S_RESP: begin
          r_state     <= S_IDLE;
          r_ptr       <= r_owner;
          r_gnt       <= '0;
          r_host_addr <= '0;
          r_busy      <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt          = r_gnt;
  assign o_rsp_valid    = r_rsp_valid;
  assign o_rsp_data     = r_rsp_data;
  assign o_busy         = r_busy;
  assign o_host_addr    = r_host_addr;
  assign o_reg_rd_start = r_reg_rd_start;
`ifdef LMAC_REG_RD_TIMEOUT_EN
  assign o_rsp_err      = r_rsp_err;
`else
  assign o_rsp_err      = 1'b0;
`endif

endmodule
